// File: rtl/act_lut_engine_if.sv
// Streaming data interface for act_lut_engine: input beat channel and output
// beat channel, each with a valid/ready handshake.
interface act_lut_engine_if #(
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 4
);
    logic [LANES*DATA_WIDTH-1:0] in_data;
    logic                        in_valid;
    logic                        in_ready;
    logic [LANES*DATA_WIDTH-1:0] out_data;
    logic [LANES-1:0]            out_keep;
    logic                        out_last;
    logic                        out_valid;
    logic                        out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_keep, out_last, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_keep, out_last, out_valid
    );
endinterface

// File: rtl/act_lut_engine.sv
// Multi-lane activation engine: input beat FIFO feeding an output register
// through a per-lane LUT / ReLU / bypass function, with a job-level FSM.
module act_lut_engine #(
    parameter int  DATA_WIDTH   = 8,
    parameter int  LANES        = 4,
    parameter int  MAX_ELEMENTS = 4096,
    parameter int  FIFO_DEPTH   = 4,
    localparam int CNT_W        = $clog2(MAX_ELEMENTS + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  clear,
    input  logic [1:0]            mode,
    input  logic [CNT_W-1:0]      num_elements,
    output logic                  busy,
    output logic                  done,
    input  logic                  lut_we,
    input  logic [DATA_WIDTH-1:0] lut_addr,
    input  logic [DATA_WIDTH-1:0] lut_wdata,
    act_lut_engine_if.slave       bus
);
    localparam int BEAT_W = LANES * DATA_WIDTH;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int LVL_W  = $clog2(FIFO_DEPTH + 1);
    localparam int EXT_W  = CNT_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                  state, state_nxt;
    logic [1:0]              mode_q;
    logic [CNT_W-1:0]        num_beats_q, in_cnt, out_cnt;
    logic [LANES-1:0]        last_keep_q;
    logic [BEAT_W-1:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr, rd_ptr;
    logic [LVL_W-1:0]        fifo_lvl;
    logic [DATA_WIDTH-1:0]   lut [2**DATA_WIDTH];

    logic [EXT_W-1:0]        elem_ext;
    logic [CNT_W-1:0]        num_beats_d, rem_d;
    logic [LANES-1:0]        keep_d;
    logic [BEAT_W-1:0]       fifo_head, lane_res;
    logic                    start_ok, push, pop, pop_last, out_fire, last_fire;

    // Job geometry is derived from the raw inputs and captured on start.
    assign elem_ext    = {1'b0, num_elements} + EXT_W'(LANES - 1);
    assign num_beats_d = CNT_W'(elem_ext / EXT_W'(LANES));
    assign rem_d       = num_elements % CNT_W'(LANES);

    always_comb begin
        keep_d = '0;
        for (int i = 0; i < LANES; i++)
            keep_d[i] = (rem_d == '0) || (CNT_W'(i) < rem_d);
    end

    assign start_ok  = (state == S_IDLE) && start && !clear;
    assign bus.in_ready = (state == S_RUN) && (in_cnt < num_beats_q)
                          && (fifo_lvl != LVL_W'(FIFO_DEPTH));
    assign push      = bus.in_valid && bus.in_ready;
    assign pop       = (fifo_lvl != '0) && (!bus.out_valid || bus.out_ready);
    assign pop_last  = (out_cnt + CNT_W'(1)) == num_beats_q;
    assign out_fire  = bus.out_valid && bus.out_ready;
    assign last_fire = out_fire && bus.out_last;
    assign fifo_head = fifo_mem[rd_ptr];

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every signal written in a combinational block gets a default first,
    // so no path through the block can leave it unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = (num_elements == '0) ? S_DONE : S_RUN;
            S_RUN:   if (last_fire) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (clear) state_nxt = S_IDLE;
    end

    always_comb begin
        logic [DATA_WIDTH-1:0] x;
        x        = '0;
        lane_res = '0;
        for (int i = 0; i < LANES; i++) begin
            x = fifo_head[i*DATA_WIDTH +: DATA_WIDTH];
            case (mode_q)
                2'd0:    lane_res[i*DATA_WIDTH +: DATA_WIDTH] = lut[x];
                2'd1:    lane_res[i*DATA_WIDTH +: DATA_WIDTH] = x[DATA_WIDTH-1] ? '0 : x;
                default: lane_res[i*DATA_WIDTH +: DATA_WIDTH] = x;
            endcase
        end
    end

    // NOTE: storage arrays are deliberately left without reset; the LUT is
    // firmware-loaded and FIFO entries are only read after being written.
    always_ff @(posedge clk) begin
        if (lut_we && (state == S_IDLE) && !start)
            lut[lut_addr] <= lut_wdata;
        if (push)
            fifo_mem[wr_ptr] <= bus.in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q      <= '0;
            num_beats_q <= '0;
            last_keep_q <= '0;
            in_cnt      <= '0;
            out_cnt     <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_lvl    <= '0;
        end else if (clear || start_ok) begin
            in_cnt   <= '0;
            out_cnt  <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_lvl <= '0;
            if (start_ok) begin
                mode_q      <= mode;
                num_beats_q <= num_beats_d;
                last_keep_q <= keep_d;
            end
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                in_cnt <= in_cnt + CNT_W'(1);
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + PTR_W'(1);
                out_cnt <= out_cnt + CNT_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_lvl <= fifo_lvl + LVL_W'(1);
                2'b01:   fifo_lvl <= fifo_lvl - LVL_W'(1);
                default: fifo_lvl <= fifo_lvl;
            endcase
        end
    end

    // Output register: loads on pop, otherwise holds its beat until accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_keep  <= '0;
            bus.out_last  <= 1'b0;
        end else if (clear) begin
            bus.out_valid <= 1'b0;
        end else if (pop) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= lane_res;
            bus.out_last  <= pop_last;
            bus.out_keep  <= pop_last ? last_keep_q : '1;
        end else if (out_fire) begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_act_lut_engine.sv
// Directed self-checking bench for act_lut_engine with hand-computed vectors.
module tb_act_lut_engine;
    localparam int DW    = 8;
    localparam int LANES = 4;
    localparam int CNT_W = $clog2(4096 + 1);

    logic             clk = 1'b0;
    logic             rst_n, start, clear, lut_we, busy, done;
    logic [1:0]       mode;
    logic [CNT_W-1:0] num_elements;
    logic [DW-1:0]    lut_addr, lut_wdata;

    act_lut_engine_if #(.DATA_WIDTH(DW), .LANES(LANES)) bus ();

    act_lut_engine #(
        .DATA_WIDTH(DW), .LANES(LANES), .MAX_ELEMENTS(4096), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .mode(mode),
        .num_elements(num_elements), .busy(busy), .done(done),
        .lut_we(lut_we), .lut_addr(lut_addr), .lut_wdata(lut_wdata), .bus(bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int acc;

    logic [31:0] in_beats [$];
    logic [31:0] exp_data [$];
    logic [3:0]  exp_keep [$];
    logic        exp_last [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // side: 0 none, 1 start pulse during RUN, 2 LUT write during RUN
    task automatic run_job(input logic [1:0] m, input int n, input int stall, input int side);
        int nb, tx, rx, cyc_tx, cyc_rx;
        nb  = exp_data.size();
        acc = 0;
        @(negedge clk);
        start = 1'b1; mode = m; num_elements = CNT_W'(n); lut_we = 1'b0;
        @(negedge clk);
        start = 1'b0;
        fork
            begin
                tx = 0; cyc_tx = 0;
                while (tx < nb && cyc_tx < 400) begin
                    @(negedge clk); cyc_tx++;
                    bus.in_valid = 1'b1;
                    bus.in_data  = in_beats[tx];
                    if (bus.in_ready) begin tx++; acc++; end
                end
                @(negedge clk);
                bus.in_valid = 1'b0;
                check("tx_beats", tx, nb);
            end
            begin
                rx = 0; cyc_rx = 0;
                while (rx < nb && cyc_rx < 400) begin
                    @(negedge clk); cyc_rx++;
                    if (cyc_rx <= stall) begin
                        bus.out_ready = 1'b0;
                        if (cyc_rx == stall) begin
                            check("bp_accepted", acc, 5);
                            check("bp_in_ready", bus.in_ready, 0);
                            check("bp_hold", bus.out_data, exp_data[0]);
                        end
                    end else begin
                        bus.out_ready = 1'b1;
                        if (bus.out_valid) begin
                            check($sformatf("data%0d", rx), bus.out_data, exp_data[rx]);
                            check($sformatf("keep%0d", rx), bus.out_keep, exp_keep[rx]);
                            check($sformatf("last%0d", rx), bus.out_last, exp_last[rx]);
                            rx++;
                        end
                    end
                end
                check("rx_beats", rx, nb);
                @(negedge clk);
                check("done_pulse", done, 1);
                check("post_valid", bus.out_valid, 0);
                @(negedge clk);
                check("done_low", done, 0);
                check("idle_busy", busy, 0);
            end
            begin
                if (side == 1) begin
                    @(negedge clk); @(negedge clk);
                    start = 1'b1; num_elements = CNT_W'(4); mode = 2'd1;
                    @(negedge clk);
                    start = 1'b0;
                end else if (side == 2) begin
                    @(negedge clk);
                    lut_we = 1'b1; lut_addr = 8'h10; lut_wdata = 8'hEE;
                    @(negedge clk);
                    lut_we = 1'b0;
                end
            end
        join
    endtask

    task automatic set_single(input logic [31:0] din, input logic [31:0] dexp);
        in_beats = '{din};
        exp_data = '{dexp};
        exp_keep = '{4'hF};
        exp_last = '{1'b1};
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int cyc;
        logic [31:0] b;
        rst_n = 1'b0; start = 1'b0; clear = 1'b0; mode = '0; num_elements = '0;
        lut_we = 1'b0; lut_addr = '0; lut_wdata = '0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_last", bus.out_last, 0);
        check("rst_out_keep", bus.out_keep, 0);
        check("rst_out_data", bus.out_data, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // LUT[i] = i ^ 8'h5A, loaded while idle
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            lut_we = 1'b1; lut_addr = 8'(i); lut_wdata = 8'(i) ^ 8'h5A;
        end
        @(negedge clk);
        lut_we = 1'b0;

        // LUT mode, two full beats
        in_beats = '{32'h807F0100, 32'h302010FF};
        exp_data = '{32'hDA255B5A, 32'h6A7A4AA5};
        exp_keep = '{4'hF, 4'hF};
        exp_last = '{1'b0, 1'b1};
        run_job(2'd0, 8, 0, 0);

        // ReLU with a partial final beat
        in_beats = '{32'h7F00FF80, 32'hC4330581};
        exp_data = '{32'h7F000000, 32'h00330500};
        exp_keep = '{4'hF, 4'b0011};
        exp_last = '{1'b0, 1'b1};
        run_job(2'd1, 6, 0, 0);

        // Backpressure in bypass, plus an ignored start (ReLU, 4 elems) mid-job
        in_beats.delete(); exp_data.delete(); exp_keep.delete(); exp_last.delete();
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 4; j++) b[j*8 +: 8] = 8'h80 + 8'(4*i + j);
            in_beats.push_back(b);
            exp_data.push_back(b);
            exp_keep.push_back(4'hF);
            exp_last.push_back(i == 7);
        end
        run_job(2'd2, 32, 10, 1);

        // Zero-length job
        @(negedge clk);
        start = 1'b1; num_elements = '0; mode = 2'd2;
        @(negedge clk);
        start = 1'b0;
        check("zero_busy", busy, 1);
        check("zero_done", done, 1);
        check("zero_valid", bus.out_valid, 0);
        @(negedge clk);
        check("zero_busy_end", busy, 0);
        check("zero_done_end", done, 0);

        // Clear after 3 of 8 beats
        @(negedge clk);
        start = 1'b1; num_elements = CNT_W'(32); mode = 2'd2;
        @(negedge clk);
        start = 1'b0; bus.out_ready = 1'b1;
        acc = 0; cyc = 0;
        while (acc < 3 && cyc < 50) begin
            @(negedge clk); cyc++;
            bus.in_valid = 1'b1; bus.in_data = 32'h01020304;
            if (bus.in_ready) acc++;
        end
        check("clr_accepted", acc, 3);
        @(negedge clk);
        bus.in_valid = 1'b0; clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clr_busy", busy, 0);
        check("clr_valid", bus.out_valid, 0);
        check("clr_in_ready", bus.in_ready, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("clr_no_done", done, 0);
        end
        set_single(32'h11223344, 32'h11223344);
        run_job(2'd2, 4, 0, 0);

        // LUT write during RUN is ignored, both in that job and the next
        set_single(32'h13121110, 32'h49484B4A);
        run_job(2'd0, 4, 0, 2);
        set_single(32'h13121110, 32'h49484B4A);
        run_job(2'd0, 4, 0, 0);

        // Same write while idle is seen by the job started on the next edge
        @(negedge clk);
        lut_we = 1'b1; lut_addr = 8'h10; lut_wdata = 8'hEE;
        set_single(32'h13121110, 32'h49484BEE);
        run_job(2'd0, 4, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
